parallel2serial_lanes: RTL and testbench

Parametrised parallel-to-serial converter that splits each `DATA_WIDTH`-bit word from the datapath into `DATA_WIDTH/LANES` beats of `LANES` bits. It replaces the fixed 1-bit, free-running serializer with a handshaked, stallable, gap-free stream. Each beat carries frame markers. The block sits between the decoding-process datapath and the serial link/test-output logic. A one-entry hold buffer lets the next word be accepted while the current word is still shifting.

---
 rtl/parallel2serial_lanes_pkg.sv | 26 ++
 rtl/p2s_hold_buf.sv | 53 +++++
 rtl/parallel2serial_lanes.sv | 111 +++++++++++
 tb/tb_parallel2serial_lanes.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/parallel2serial_lanes_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | parallel2serial_lanes_pkg: shared width default, shifter state,  |
// | and clog2 helper for the lane serializer.   Revision: 1.0        |
// +------------------------------------------------------------------+
package parallel2serial_lanes_pkg;

  localparam int c_DATAPATH_WIDTH = 16;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } p2s_state_t;

  // Ceiling log2, never below 1 so a counter always has at least one bit.
  function automatic int p2s_clog2(input int value);
    int result;
    result = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage
`default_nettype wire

// File: rtl/p2s_hold_buf.sv
`default_nettype none
// +------------------------------------------------------------------+
// | p2s_hold_buf: one-entry valid/ready word buffer with flush.      |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module p2s_hold_buf
  import parallel2serial_lanes_pkg::*;
#(
  parameter int WIDTH = c_DATAPATH_WIDTH
) (
  input  logic             serial_clk,
  input  logic             rstn,
  input  logic             i_flush,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic             i_load,
  output logic [WIDTH-1:0] o_data,
  output logic             o_valid
);

  logic             r_rstn_q;
  logic             r_valid;
  logic [WIDTH-1:0] r_data;
  logic             w_accept;

  // Ready stays low for one cycle after reset release via r_rstn_q.
  assign o_ready  = r_rstn_q && !r_valid && !i_flush;
  assign w_accept = i_valid && o_ready;

  always_ff @(posedge serial_clk) begin
    if (!rstn) begin
      r_rstn_q <= 1'b0;
      r_valid  <= 1'b0;
      r_data   <= '0;
    end else begin
      r_rstn_q <= 1'b1;
      if (i_flush) begin
        r_valid <= 1'b0;
      end else if (w_accept) begin
        r_valid <= 1'b1;
        r_data  <= i_data;
      end else if (i_load) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign o_data  = r_data;
  assign o_valid = r_valid;

endmodule
`default_nettype wire

// File: rtl/parallel2serial_lanes.sv
`default_nettype none
// +------------------------------------------------------------------+
// | parallel2serial_lanes: handshaked word-to-lane-beat serializer   |
// | with frame markers and flush.               Revision: 1.0        |
// +------------------------------------------------------------------+
module parallel2serial_lanes
  import parallel2serial_lanes_pkg::*;
#(
  parameter int DATA_WIDTH = c_DATAPATH_WIDTH,
  parameter int LANES      = 4,
  parameter bit MSB_FIRST  = 1'b1
) (
  input  logic                  serial_clk,
  input  logic                  rstn,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  flush,
  output logic [LANES-1:0]      serial_data,
  output logic                  serial_valid,
  input  logic                  out_ready,
  output logic                  frame_first,
  output logic                  frame_last
);

  localparam int c_BEATS = DATA_WIDTH / LANES;
  localparam int c_CNT_W = p2s_clog2(c_BEATS);
  localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(c_BEATS - 1);

  generate
    if ((DATA_WIDTH % LANES) != 0 || c_BEATS < 2) begin : g_param_check
      $error("parallel2serial_lanes: DATA_WIDTH must be a multiple of LANES with at least 2 beats");
    end
  endgenerate

  p2s_state_t            r_state, w_state_nxt;
  logic [DATA_WIDTH-1:0] r_sreg, w_sreg_nxt, w_sreg_shift, w_hbuf;
  logic [c_CNT_W-1:0]    r_cnt, w_cnt_nxt;
  logic [LANES-1:0]      w_lane;
  logic                  w_hvalid, w_beat, w_last_beat, w_load;

  p2s_hold_buf #(.WIDTH(DATA_WIDTH)) u_hold_buf (
    .serial_clk (serial_clk),
    .rstn       (rstn),
    .i_flush    (flush),
    .i_data     (data_in),
    .i_valid    (in_valid),
    .o_ready    (in_ready),
    .i_load     (w_load),
    .o_data     (w_hbuf),
    .o_valid    (w_hvalid)
  );

  generate
    if (MSB_FIRST) begin : g_msb_first
      assign w_sreg_shift = r_sreg << LANES;
      assign w_lane       = r_sreg[DATA_WIDTH-1 -: LANES];
    end else begin : g_lsb_first
      assign w_sreg_shift = r_sreg >> LANES;
      assign w_lane       = r_sreg[LANES-1:0];
    end
  endgenerate

  assign w_beat      = (r_state == ST_SHIFT) && out_ready;
  assign w_last_beat = (r_cnt == c_LAST);
  // Reloading on the last-beat handshake is what keeps words gap-free.
  assign w_load      = w_hvalid && !flush &&
                       ((r_state == ST_IDLE) || (w_beat && w_last_beat));

  always_comb begin
    w_state_nxt = r_state;
    w_sreg_nxt  = r_sreg;
    w_cnt_nxt   = r_cnt;
    if (flush) begin
      w_state_nxt = ST_IDLE;
      w_sreg_nxt  = '0;
      w_cnt_nxt   = '0;
    end else if (w_load) begin
      w_state_nxt = ST_SHIFT;
      w_sreg_nxt  = w_hbuf;
      w_cnt_nxt   = '0;
    end else if (w_beat) begin
      if (w_last_beat) begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end else begin
        w_cnt_nxt  = r_cnt + 1'b1;
        w_sreg_nxt = w_sreg_shift;
      end
    end
  end

  always_ff @(posedge serial_clk) begin
    if (!rstn) begin
      r_state <= ST_IDLE;
      r_sreg  <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_sreg  <= w_sreg_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  assign serial_valid = (r_state == ST_SHIFT);
  assign serial_data  = serial_valid ? w_lane : '0;
  assign frame_first  = serial_valid && (r_cnt == '0);
  assign frame_last   = serial_valid && w_last_beat;

endmodule
`default_nettype wire

// File: tb/tb_parallel2serial_lanes.sv
`default_nettype none
// Bench for parallel2serial_lanes: MSB-first and LSB-first instances share
// stimulus and are compared each cycle against a word/beat-index model.
module tb_parallel2serial_lanes;

  localparam int BEATS = 4;

  logic        serial_clk = 1'b0;
  logic        rstn       = 1'b0;
  logic        in_valid   = 1'b0;
  logic        flush      = 1'b0;
  logic        out_ready  = 1'b1;
  logic [15:0] data_in    = 16'h0;

  logic       d_msb_in_ready, d_msb_valid, d_msb_first, d_msb_last;
  logic [3:0] d_msb_data;
  logic       d_lsb_in_ready, d_lsb_valid, d_lsb_first, d_lsb_last;
  logic [3:0] d_lsb_data;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;
  int cyc      = 0;

  always #5 serial_clk = ~serial_clk;

  parallel2serial_lanes #(.DATA_WIDTH(16), .LANES(4), .MSB_FIRST(1'b1)) u_dut_msb (
    .serial_clk (serial_clk), .rstn (rstn), .data_in (data_in), .in_valid (in_valid),
    .in_ready (d_msb_in_ready), .flush (flush), .serial_data (d_msb_data),
    .serial_valid (d_msb_valid), .out_ready (out_ready),
    .frame_first (d_msb_first), .frame_last (d_msb_last));

  parallel2serial_lanes #(.DATA_WIDTH(16), .LANES(4), .MSB_FIRST(1'b0)) u_dut_lsb (
    .serial_clk (serial_clk), .rstn (rstn), .data_in (data_in), .in_valid (in_valid),
    .in_ready (d_lsb_in_ready), .flush (flush), .serial_data (d_lsb_data),
    .serial_valid (d_lsb_valid), .out_ready (out_ready),
    .frame_first (d_lsb_first), .frame_last (d_lsb_last));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Model: a held word, the word on the wire and which beat of it is showing.
  bit          md_rstn_q = 0, md_held_v = 0, md_active = 0;
  logic [15:0] md_held_w = 0, md_word = 0;
  int          md_beat   = 0;

  function automatic logic [3:0] lane(input logic [15:0] w, input int k, input bit msb);
    int sh;
    sh = msb ? 4 * (BEATS - 1 - k) : 4 * k;
    return 4'((w >> sh) & 16'hF);
  endfunction

  always @(posedge serial_clk) begin : model
    bit acc, hs, last;
    cyc++;
    acc  = in_valid && md_rstn_q && !md_held_v && !flush;
    hs   = md_active && out_ready;
    last = (md_beat == BEATS - 1);
    if (!rstn) begin
      md_rstn_q = 0; md_held_v = 0; md_active = 0; md_beat = 0;
    end else begin
      md_rstn_q = 1;
      if (flush) begin
        md_held_v = 0; md_active = 0; md_beat = 0;
      end else begin
        if (hs && !last) begin
          md_beat++;
        end else if (!md_active || (hs && last)) begin
          if (md_held_v) begin
            md_word = md_held_w; md_beat = 0; md_active = 1; md_held_v = 0;
          end else begin
            md_active = 0; md_beat = 0;
          end
        end
        if (acc) begin
          md_held_w = data_in; md_held_v = 1;
        end
      end
    end
  end

  // Captured beat stream from both instances.
  logic [31:0] cap_msb = 0, cap_lsb = 0;
  int n_beats = 0, n_last = 0, first_cyc = 0, last_cyc = 0;

  always @(negedge serial_clk) begin : compare
    if (chk_en) begin
      chk("msb_valid", d_msb_valid, md_active);
      chk("lsb_valid", d_lsb_valid, md_active);
      chk("msb_data", d_msb_data, md_active ? lane(md_word, md_beat, 1'b1) : 4'h0);
      chk("lsb_data", d_lsb_data, md_active ? lane(md_word, md_beat, 1'b0) : 4'h0);
      chk("msb_first", d_msb_first, md_active && md_beat == 0);
      chk("lsb_first", d_lsb_first, md_active && md_beat == 0);
      chk("msb_last", d_msb_last, md_active && md_beat == BEATS - 1);
      chk("lsb_last", d_lsb_last, md_active && md_beat == BEATS - 1);
      chk("msb_in_ready", d_msb_in_ready, md_rstn_q && !md_held_v && !flush);
      chk("lsb_in_ready", d_lsb_in_ready, md_rstn_q && !md_held_v && !flush);
    end
    if (d_msb_valid && out_ready) begin
      cap_msb = {cap_msb[27:0], d_msb_data};
      cap_lsb = {cap_lsb[27:0], d_lsb_data};
      n_beats++;
      if (n_beats == 1) first_cyc = cyc;
      last_cyc = cyc;
      if (d_msb_last) n_last++;
    end
  end

  task automatic step();
    @(posedge serial_clk);
    #1;
  endtask

  task automatic clear_cap();
    cap_msb = 0; cap_lsb = 0; n_beats = 0; n_last = 0;
  endtask

  task automatic send(input logic [15:0] w);
    bit done;
    done = 0;
    data_in  = w;
    in_valid = 1'b1;
    for (int t = 0; t < 40 && !done; t++) begin
      if (d_msb_in_ready) done = 1;
      step();
    end
    if (!done) begin
      checks++; failures++;
      $display("FAIL send_timeout word=%0h actual=no_accept required=accept", w);
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_msb_data(input logic [3:0] v);
    bit seen;
    seen = 0;
    for (int t = 0; t < 40 && !seen; t++) begin
      if (d_msb_valid && d_msb_data == v) seen = 1;
      else step();
    end
    if (!seen) begin
      checks++; failures++;
      $display("FAIL wait_beat_timeout actual=absent required=%0h", v);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset and release
    repeat (3) step();
    chk_en = 1'b1;
    chk("rst_valid", d_msb_valid, 1'b0);
    chk("rst_data", d_msb_data, 4'h0);
    chk("rst_in_ready", d_msb_in_ready, 1'b0);
    rstn = 1'b1;
    chk("rel_in_ready_lo", d_msb_in_ready, 1'b0);
    step();
    chk("rel_in_ready_hi", d_msb_in_ready, 1'b1);

    // Single word, two-cycle latency, both orders
    clear_cap();
    send(16'hA5C3);
    chk("lat_not_yet", d_msb_valid, 1'b0);
    chk("lat_hbuf_full", d_msb_in_ready, 1'b0);
    step();
    chk("lat_beat0_msb", d_msb_data, 4'hA);
    chk("lat_beat0_lsb", d_lsb_data, 4'h3);
    chk("lat_first", d_msb_first, 1'b1);
    repeat (6) step();
    chk("s1_msb_stream", cap_msb[15:0], 16'hA5C3);
    chk("s1_lsb_stream", cap_lsb[15:0], 16'h3C5A);
    chk("s1_beats", n_beats, 4);
    chk("s1_last_count", n_last, 1);
    chk("s1_idle", d_msb_valid, 1'b0);

    // Back-to-back words, gap-free
    clear_cap();
    send(16'h1234);
    send(16'h5678);
    repeat (10) step();
    chk("b2b_stream", cap_msb, 32'h12345678);
    chk("b2b_beats", n_beats, 8);
    chk("b2b_no_gap", last_cyc - first_cyc, 7);
    chk("b2b_last_count", n_last, 2);

    // Backpressure on beat 3
    clear_cap();
    send(16'h1234);
    wait_msb_data(4'h3);
    out_ready = 1'b0;
    repeat (3) begin
      step();
      chk("bp_data", d_msb_data, 4'h3);
      chk("bp_flags", {d_msb_first, d_msb_last}, 2'b00);
    end
    out_ready = 1'b1;
    step();
    chk("bp_next", d_msb_data, 4'h4);
    chk("bp_next_last", d_msb_last, 1'b1);
    repeat (4) step();
    chk("bp_stream", cap_msb[15:0], 16'h1234);

    // Flush mid-frame with a word buffered
    clear_cap();
    send(16'hBEEF);
    send(16'hCAFE);
    chk("fl_pre_beat", d_msb_data, 4'hE);
    flush = 1'b1;
    chk("fl_in_ready", d_msb_in_ready, 1'b0);
    step();
    flush = 1'b0;
    chk("fl_idle_valid", d_msb_valid, 1'b0);
    chk("fl_idle_data", d_msb_data, 4'h0);
    repeat (4) step();
    chk("fl_dropped_beats", n_beats, 2);
    chk("fl_no_last", n_last, 0);
    clear_cap();
    send(16'h0F0F);
    repeat (6) step();
    chk("fl_resume_msb", cap_msb[15:0], 16'h0F0F);
    chk("fl_resume_lsb", cap_lsb[15:0], 16'hF0F0);
    chk("fl_resume_last", n_last, 1);

    // Reset mid-frame
    clear_cap();
    send(16'h1234);
    wait_msb_data(4'h3);
    rstn = 1'b0;
    step();
    chk("mrst_valid", d_msb_valid, 1'b0);
    chk("mrst_data", d_msb_data, 4'h0);
    chk("mrst_in_ready", d_msb_in_ready, 1'b0);
    step();
    rstn = 1'b1;
    chk("mrst_rel_lo", d_msb_in_ready, 1'b0);
    step();
    chk("mrst_rel_hi", d_msb_in_ready, 1'b1);
    chk("mrst_no_last", n_last, 0);
    repeat (2) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
